arbitro_memoria_dados: RTL and testbench
========================================

# arbitro_memoria_dados

Arbitrates the single-port data memory between the pipeline's MEM stage and the UART bridge, which loads and inspects data memory while the processor runs. The CPU has priority by default. A pending UART transaction is served in the first cycle the MEM stage leaves the memory idle. If the UART waits too long, the block forces a UART access and freezes the pipeline for exactly one cycle. It sits between the EX/MEM pipeline registers, the UART bridge and the data memory instance.

## Interface
- LARGURA_DADO, 32, data word width
- LARGURA_END, 7, word address width (128 words)
- MAX_ESPERA, 4, maximum count of UART wait cycles before a forced grant; must be ≥1

- clock  in  1  system clock; all state updates on posedge
- reset_n  in  1  synchronous, active-low reset
- cpu_ler / cpu_escrever  in  1 / 1  MEM-stage read and write strobes
- cpu_endereco  in  LARGURA_END  MEM-stage word address
- cpu_dado_escrever  in  LARGURA_DADO  MEM-stage store data
- cpu_dado_ler  out  LARGURA_DADO  load data, equal to mem_dado_ler (combinational)
- cpu_parada  out  1  freeze request to the pipeline (PC and all stage registers hold)
- uart_req  in  1  UART transaction request (level)
- uart_escrever  in  1  1 = write, 0 = read
- uart_endereco  in  LARGURA_END  UART word address
- uart_dado_escrever  in  LARGURA_DADO  UART write data
- uart_ack  out  1  one-cycle completion pulse, registered
- uart_dado_ler  out  LARGURA_DADO  registered read data, valid while uart_ack is high
- mem_ler / mem_escrever  out  1 / 1  strobes to data memory
- mem_endereco  out  LARGURA_END  address to data memory
- mem_dado_escrever  out  LARGURA_DADO  write data to data memory
- mem_dado_ler  in  LARGURA_DADO  combinational read data from data memory

## Operation
- CPU is busy when cpu_ler | cpu_escrever. Its strobes pass through unchanged, including the illegal case where both are set.
- Memory-port owner, decided per cycle:
  - UART owns the port in any serve cycle.
  - Otherwise the CPU owns it.
  - When the UART owns the port, mem_* take the uart_* values, with mem_ler = ~uart_escrever.
- State machine:
  - OCIOSO:
    - uart_req and CPU idle: serve now, go to RESP.
    - uart_req and CPU busy: go to ESPERA, contador = 1.
  - ESPERA:
    - CPU idle: serve, go to RESP.
    - CPU busy and contador == MAX_ESPERA: forced serve with cpu_parada = 1, go to RESP.
    - Otherwise: contador + 1, stay in ESPERA.
  - RESP:
    - uart_ack = 1. No UART access in this cycle; the CPU owns the port.
    - Go to OCIOSO and clear contador.
- On a serve cycle, mem_dado_ler is captured into uart_dado_ler at the clock edge.
- A forced cycle suppresses the CPU access; a CPU write in that cycle must not reach memory. The frozen pipeline replays the access on the next cycle.
- cpu_parada is combinational from state, contador and CPU busy. It is asserted only in a forced cycle.
- UART master protocol:
  - Hold address, data and write bit stable while uart_req is high and no ack has arrived.
  - In the cycle after the ack, either drop uart_req or present the next transaction.
  - A uart_req that is high in RESP is evaluated in OCIOSO on the following cycle.
- Reset (reset_n low at a clock edge):
  - State OCIOSO, contador 0, uart_ack 0, uart_dado_ler 0.
  - While reset_n is low, cpu_parada, mem_ler and mem_escrever are forced to 0.
  - An in-flight unacknowledged UART request is dropped. If uart_req is still high after reset, it is served as a new request.

## Timing
- Uncontended UART access: access in cycle 0 (the cycle uart_req is first seen in OCIOSO), ack in cycle 1.
- Worst case: forced access in cycle MAX_ESPERA, ack in cycle MAX_ESPERA+1.
- Minimum spacing between UART transactions is 2 cycles (access cycle + RESP).
- The CPU stalls at most 1 cycle per UART transaction.
- CPU accesses add zero latency when uncontended.
- contador width is $clog2(MAX_ESPERA+1). It never exceeds MAX_ESPERA.

## Structure
- Shared package `pacote_memoria`: state encodings OCIOSO = 2'b00, ESPERA = 2'b01, RESP = 2'b10, plus the LARGURA_DADO and LARGURA_END defaults. The UART bridge reuses this package.
- One natural combinational sub-module, `mux_porta_memoria`: selects CPU or UART signals onto mem_* from a single `sel_uart` input and gates the strobes during reset.
- The FSM and contador stay in the top-level module.

## Test plan
- **Uncontended write:** CPU idle, UART writes 32'hDEADBEEF to address 7'h05. Expect mem_escrever = 1 with mem_endereco = 5 in cycle 0, uart_ack = 1 in cycle 1, cpu_parada = 0 throughout.
- **Read-back:** UART reads address 7'h05 with CPU idle. Expect uart_dado_ler = 32'hDEADBEEF in the same cycle as uart_ack, and uart_ack high for exactly 1 cycle.
- **Starvation, MAX_ESPERA = 4:** cpu_ler = 1 every cycle, uart_req rises at cycle 0. Expect cpu_parada = 1 only in cycle 4, mem_endereco = UART address in cycle 4, uart_ack in cycle 5.
- **Idle slot:** CPU busy in cycles 0–1 and idle in cycle 2. Expect the UART served in cycle 2 with cpu_parada = 0, ack in cycle 3, and the next request starting again from contador = 1.
- **Forced-cycle store:** CPU stores 32'h12345678 to address 7'h03 during a forced cycle. Expect address 3 unchanged in that cycle and written one cycle later after the replay.
- **Reset in ESPERA:** pulse reset_n low while in ESPERA. Expect no ack, all outputs 0 during reset. With uart_req still high, expect service in the first cycle after reset, provided the CPU is idle.

Source files
------------

// File: rtl/arbitro_memoria_dados_pkg.sv
// pacote_memoria
//   Shared definitions for the data-memory arbiter and the UART bridge:
//   FSM state encodings, default word/address widths and the width helper
//   for the UART wait counter.
package pacote_memoria;

  localparam int LARGURA_DADO_PADRAO = 32;
  localparam int LARGURA_END_PADRAO  = 7;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    ESPERA = 2'b01,
    RESP   = 2'b10
  } estado_t;

  // Bits needed to count from 0 up to max_espera inclusive.
  function automatic int largura_contador(input int max_espera);
    return $clog2(max_espera + 1);
  endfunction

endpackage

// File: rtl/arbitro_memoria_dados_mux.sv
// mux_porta_memoria
//   Combinational selector for the single data-memory port.
//   i_sel_uart    : 1 = UART drives the port, 0 = CPU drives it
//   i_habilita    : 0 forces both memory strobes low (held in reset)
//   i_cpu_*       : MEM-stage strobes, address and store data
//   i_uart_*      : UART bridge write bit, address and write data
//   o_mem_*       : strobes, address and write data to data memory
import pacote_memoria::*;

module mux_porta_memoria #(
  parameter int LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int LARGURA_END  = LARGURA_END_PADRAO
) (
  input  logic                    i_sel_uart,
  input  logic                    i_habilita,
  input  logic                    i_cpu_ler,
  input  logic                    i_cpu_escrever,
  input  logic [LARGURA_END-1:0]  i_cpu_endereco,
  input  logic [LARGURA_DADO-1:0] i_cpu_dado_escrever,
  input  logic                    i_uart_escrever,
  input  logic [LARGURA_END-1:0]  i_uart_endereco,
  input  logic [LARGURA_DADO-1:0] i_uart_dado_escrever,
  output logic                    o_mem_ler,
  output logic                    o_mem_escrever,
  output logic [LARGURA_END-1:0]  o_mem_endereco,
  output logic [LARGURA_DADO-1:0] o_mem_dado_escrever
);

  logic w_ler;
  logic w_escrever;

  always_comb begin
    if (i_sel_uart) begin
      w_ler               = ~i_uart_escrever;
      w_escrever          = i_uart_escrever;
      o_mem_endereco      = i_uart_endereco;
      o_mem_dado_escrever = i_uart_dado_escrever;
    end else begin
      // CPU strobes pass through untouched, even if both are set.
      w_ler               = i_cpu_ler;
      w_escrever          = i_cpu_escrever;
      o_mem_endereco      = i_cpu_endereco;
      o_mem_dado_escrever = i_cpu_dado_escrever;
    end
  end

  assign o_mem_ler      = w_ler & i_habilita;
  assign o_mem_escrever = w_escrever & i_habilita;

endmodule

// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados
//   Shares the single-port data memory between the MEM stage (priority)
//   and the UART bridge. A waiting UART request is served in the first
//   cycle the CPU leaves the port idle; after MAX_ESPERA busy cycles the
//   UART access is forced and the pipeline is frozen for that one cycle.
//   i_clock / i_reset_n        : clock, synchronous active-low reset
//   i_cpu_* / o_cpu_*          : MEM-stage access, load data, freeze request
//   i_uart_* / o_uart_*        : UART transaction request, ack pulse, read data
//   o_mem_* / i_mem_dado_ler   : data memory port
//
//   state  | meaning
//   OCIOSO | no UART transaction pending
//   ESPERA | UART pending, CPU holding the port; r_contador counts waits
//   RESP   | UART served last cycle; ack high, CPU owns the port
import pacote_memoria::*;

module arbitro_memoria_dados #(
  parameter int LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int LARGURA_END  = LARGURA_END_PADRAO,
  parameter int MAX_ESPERA   = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_cpu_ler,
  input  logic                    i_cpu_escrever,
  input  logic [LARGURA_END-1:0]  i_cpu_endereco,
  input  logic [LARGURA_DADO-1:0] i_cpu_dado_escrever,
  output logic [LARGURA_DADO-1:0] o_cpu_dado_ler,
  output logic                    o_cpu_parada,
  input  logic                    i_uart_req,
  input  logic                    i_uart_escrever,
  input  logic [LARGURA_END-1:0]  i_uart_endereco,
  input  logic [LARGURA_DADO-1:0] i_uart_dado_escrever,
  output logic                    o_uart_ack,
  output logic [LARGURA_DADO-1:0] o_uart_dado_ler,
  output logic                    o_mem_ler,
  output logic                    o_mem_escrever,
  output logic [LARGURA_END-1:0]  o_mem_endereco,
  output logic [LARGURA_DADO-1:0] o_mem_dado_escrever,
  input  logic [LARGURA_DADO-1:0] i_mem_dado_ler
);

  localparam int LARGURA_CONT = largura_contador(MAX_ESPERA);
  localparam logic [LARGURA_CONT-1:0] C_MAX = LARGURA_CONT'(MAX_ESPERA);
  localparam logic [LARGURA_CONT-1:0] C_UM  = LARGURA_CONT'(1);

  estado_t                  r_estado;
  estado_t                  w_prox_estado;
  logic [LARGURA_CONT-1:0]  r_contador;
  logic [LARGURA_CONT-1:0]  w_prox_contador;
  logic                     r_uart_ack;
  logic [LARGURA_DADO-1:0]  r_uart_dado_ler;
  logic                     w_cpu_ocupada;
  logic                     w_servir;
  logic                     w_forcado;

  assign w_cpu_ocupada = i_cpu_ler | i_cpu_escrever;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_estado        <= OCIOSO;
      r_contador      <= '0;
      r_uart_ack      <= 1'b0;
      r_uart_dado_ler <= '0;
    end else begin
      r_estado   <= w_prox_estado;
      r_contador <= w_prox_contador;
      r_uart_ack <= w_servir;
      if (w_servir) begin
        r_uart_dado_ler <= i_mem_dado_ler;
      end
    end
  end

  always_comb begin
    w_prox_estado   = r_estado;
    w_prox_contador = r_contador;
    w_servir        = 1'b0;
    w_forcado       = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (i_uart_req) begin
          if (!w_cpu_ocupada) begin
            w_servir      = 1'b1;
            w_prox_estado = RESP;
          end else begin
            w_prox_estado   = ESPERA;
            w_prox_contador = C_UM;
          end
        end
      end
      ESPERA: begin
        if (!w_cpu_ocupada) begin
          w_servir      = 1'b1;
          w_prox_estado = RESP;
        end else if (r_contador == C_MAX) begin
          w_servir      = 1'b1;
          w_forcado     = 1'b1;
          w_prox_estado = RESP;
        end else begin
          w_prox_contador = r_contador + C_UM;
        end
      end
      RESP: begin
        // A request still high here is looked at again from OCIOSO.
        w_prox_estado   = OCIOSO;
        w_prox_contador = '0;
      end
      default: begin
        w_prox_estado   = OCIOSO;
        w_prox_contador = '0;
      end
    endcase
  end

  // In a forced cycle the UART takes the port, so the CPU access (a store
  // in particular) never reaches memory; the frozen pipeline replays it.
  mux_porta_memoria #(
    .LARGURA_DADO (LARGURA_DADO),
    .LARGURA_END  (LARGURA_END)
  ) u_mux (
    .i_sel_uart           (w_servir),
    .i_habilita           (i_reset_n),
    .i_cpu_ler            (i_cpu_ler),
    .i_cpu_escrever       (i_cpu_escrever),
    .i_cpu_endereco       (i_cpu_endereco),
    .i_cpu_dado_escrever  (i_cpu_dado_escrever),
    .i_uart_escrever      (i_uart_escrever),
    .i_uart_endereco      (i_uart_endereco),
    .i_uart_dado_escrever (i_uart_dado_escrever),
    .o_mem_ler            (o_mem_ler),
    .o_mem_escrever       (o_mem_escrever),
    .o_mem_endereco       (o_mem_endereco),
    .o_mem_dado_escrever  (o_mem_dado_escrever)
  );

  assign o_cpu_dado_ler  = i_mem_dado_ler;
  assign o_cpu_parada    = w_forcado & i_reset_n;
  assign o_uart_ack      = r_uart_ack;
  assign o_uart_dado_ler = r_uart_dado_ler;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
module tb_arbitro_memoria_dados;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_ler, cpu_escrever;
  logic [6:0]  cpu_endereco;
  logic [31:0] cpu_dado_escrever;
  logic [31:0] cpu_dado_ler;
  logic        cpu_parada;
  logic        uart_req, uart_escrever;
  logic [6:0]  uart_endereco;
  logic [31:0] uart_dado_escrever;
  logic        uart_ack;
  logic [31:0] uart_dado_ler;
  logic        mem_ler, mem_escrever;
  logic [6:0]  mem_endereco;
  logic [31:0] mem_dado_escrever;
  logic [31:0] mem_dado_ler;

  logic [31:0] tb_mem [128];
  int ciclo = 0;
  int n_total = 0;
  int n_ok = 0;

  typedef struct {
    int          ciclo;
    logic [31:0] dado;
    bit          checa_dado;
  } ack_esp_t;

  typedef struct {
    int         ciclo;
    logic [6:0] endereco;
    logic       escrever;
  } parada_esp_t;

  ack_esp_t    q_ack[$];
  parada_esp_t q_parada[$];

  always #5 clock = ~clock;

  arbitro_memoria_dados #(
    .LARGURA_DADO (32),
    .LARGURA_END  (7),
    .MAX_ESPERA   (4)
  ) dut (
    .i_clock              (clock),
    .i_reset_n            (reset_n),
    .i_cpu_ler            (cpu_ler),
    .i_cpu_escrever       (cpu_escrever),
    .i_cpu_endereco       (cpu_endereco),
    .i_cpu_dado_escrever  (cpu_dado_escrever),
    .o_cpu_dado_ler       (cpu_dado_ler),
    .o_cpu_parada         (cpu_parada),
    .i_uart_req           (uart_req),
    .i_uart_escrever      (uart_escrever),
    .i_uart_endereco      (uart_endereco),
    .i_uart_dado_escrever (uart_dado_escrever),
    .o_uart_ack           (uart_ack),
    .o_uart_dado_ler      (uart_dado_ler),
    .o_mem_ler            (mem_ler),
    .o_mem_escrever       (mem_escrever),
    .o_mem_endereco       (mem_endereco),
    .o_mem_dado_escrever  (mem_dado_escrever),
    .i_mem_dado_ler       (mem_dado_ler)
  );

  // Data memory model: combinational read, write on the clock edge.
  initial begin
    for (int i = 0; i < 128; i++) tb_mem[i] = 32'h0;
  end
  assign mem_dado_ler = tb_mem[mem_endereco];
  always @(posedge clock) begin
    if (mem_escrever) tb_mem[mem_endereco] <= mem_dado_escrever;
    ciclo <= ciclo + 1;
  end

  task automatic checa(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_total++;
    if (atual === esperado) n_ok++;
    else $display("FAIL %s: obtido %0h esperado %0h (ciclo %0d)", nome, atual, esperado, ciclo);
  endtask

  task automatic prox;
    @(posedge clock);
    #1;
  endtask

  task automatic uart_pede(input logic esc, input logic [6:0] ender, input logic [31:0] dado);
    uart_req           = 1'b1;
    uart_escrever      = esc;
    uart_endereco      = ender;
    uart_dado_escrever = dado;
  endtask

  task automatic espera_ack(input int c, input logic [31:0] dado, input bit chk);
    ack_esp_t e;
    e.ciclo = c; e.dado = dado; e.checa_dado = chk;
    q_ack.push_back(e);
  endtask

  task automatic espera_parada(input int c, input logic [6:0] ender, input logic esc);
    parada_esp_t e;
    e.ciclo = c; e.endereco = ender; e.escrever = esc;
    q_parada.push_back(e);
  endtask

  // Monitor: every ack and every freeze must match a queued expectation.
  always @(negedge clock) begin
    ack_esp_t    ea;
    parada_esp_t ep;
    if (uart_ack === 1'b1) begin
      n_total++;
      if (q_ack.size() == 0) begin
        $display("FAIL ack_inesperado: obtido ack no ciclo %0d esperado nenhum", ciclo);
      end else begin
        ea = q_ack.pop_front();
        if (ea.ciclo == ciclo && (!ea.checa_dado || uart_dado_ler === ea.dado)) n_ok++;
        else $display("FAIL ack: obtido ciclo %0d dado %0h esperado ciclo %0d dado %0h",
                      ciclo, uart_dado_ler, ea.ciclo, ea.dado);
      end
    end
    if (cpu_parada === 1'b1) begin
      n_total++;
      if (q_parada.size() == 0) begin
        $display("FAIL parada_inesperada: obtido parada no ciclo %0d esperado nenhuma", ciclo);
      end else begin
        ep = q_parada.pop_front();
        if (ep.ciclo == ciclo && mem_endereco === ep.endereco &&
            mem_escrever === ep.escrever && mem_ler === ~ep.escrever) n_ok++;
        else $display("FAIL parada: obtido ciclo %0d end %0h esc %0b esperado ciclo %0d end %0h esc %0b",
                      ciclo, mem_endereco, mem_escrever, ep.ciclo, ep.endereco, ep.escrever);
      end
    end
  end

  initial begin
    int t;
    reset_n = 1'b0;
    cpu_ler = 1'b0; cpu_escrever = 1'b0; cpu_endereco = '0; cpu_dado_escrever = '0;
    uart_req = 1'b0; uart_escrever = 1'b0; uart_endereco = '0; uart_dado_escrever = '0;
    prox; prox;
    @(negedge clock);
    checa("reset_ack", {31'b0, uart_ack}, 32'h0);
    checa("reset_dado", uart_dado_ler, 32'h0);
    checa("reset_parada", {31'b0, cpu_parada}, 32'h0);
    prox;
    reset_n = 1'b1;
    prox;

    // Uncontended write
    t = ciclo;
    uart_pede(1'b1, 7'h05, 32'hDEADBEEF);
    espera_ack(t + 1, 32'h0, 1'b0);
    @(negedge clock);
    checa("esc_mem_escrever", {31'b0, mem_escrever}, 32'h1);
    checa("esc_mem_endereco", {25'b0, mem_endereco}, 32'h5);
    checa("esc_mem_dado", mem_dado_escrever, 32'hDEADBEEF);
    prox;
    uart_req = 1'b0;
    prox;

    // Read-back
    t = ciclo;
    uart_pede(1'b0, 7'h05, 32'h0);
    espera_ack(t + 1, 32'hDEADBEEF, 1'b1);
    prox;
    uart_req = 1'b0;
    prox;

    // Starvation: forced access in cycle 4, ack in cycle 5
    t = ciclo;
    cpu_ler = 1'b1; cpu_endereco = 7'h10;
    uart_pede(1'b0, 7'h05, 32'h0);
    espera_parada(t + 4, 7'h05, 1'b0);
    espera_ack(t + 5, 32'hDEADBEEF, 1'b1);
    repeat (5) prox;
    uart_req = 1'b0;
    prox;
    cpu_ler = 1'b0;
    prox;

    // Idle slot in cycle 2, then a fresh request counts from 1 again
    t = ciclo;
    cpu_ler = 1'b1;
    uart_pede(1'b1, 7'h20, 32'hA5A5A5A5);
    espera_ack(t + 3, 32'h0, 1'b0);
    prox; prox;
    cpu_ler = 1'b0;
    @(negedge clock);
    checa("janela_mem_escrever", {31'b0, mem_escrever}, 32'h1);
    checa("janela_mem_endereco", {25'b0, mem_endereco}, 32'h20);
    prox;
    uart_req = 1'b0;
    prox;
    t = ciclo;
    cpu_ler = 1'b1;
    uart_pede(1'b0, 7'h20, 32'h0);
    espera_parada(t + 4, 7'h20, 1'b0);
    espera_ack(t + 5, 32'hA5A5A5A5, 1'b1);
    repeat (5) prox;
    uart_req = 1'b0;
    prox;
    cpu_ler = 1'b0;
    @(negedge clock);
    checa("mem_20", tb_mem[7'h20], 32'hA5A5A5A5);
    prox;

    // Store falling on the forced cycle is suppressed, then replayed
    t = ciclo;
    cpu_ler = 1'b1; cpu_endereco = 7'h10;
    uart_pede(1'b0, 7'h05, 32'h0);
    espera_parada(t + 4, 7'h05, 1'b0);
    espera_ack(t + 5, 32'hDEADBEEF, 1'b1);
    repeat (4) prox;
    cpu_ler = 1'b0; cpu_escrever = 1'b1; cpu_endereco = 7'h03; cpu_dado_escrever = 32'h12345678;
    prox;
    uart_req = 1'b0;
    @(negedge clock);
    checa("forcado_mem3_intacto", tb_mem[7'h03], 32'h0);
    prox;
    cpu_escrever = 1'b0;
    @(negedge clock);
    checa("replay_mem3", tb_mem[7'h03], 32'h12345678);
    prox;

    // Reset while in ESPERA; request still high is served right after
    cpu_ler = 1'b1; cpu_endereco = 7'h10;
    uart_pede(1'b0, 7'h20, 32'h0);
    prox;
    reset_n = 1'b0;
    @(negedge clock);
    checa("rst_mem_ler", {31'b0, mem_ler}, 32'h0);
    checa("rst_mem_escrever", {31'b0, mem_escrever}, 32'h0);
    checa("rst_parada", {31'b0, cpu_parada}, 32'h0);
    prox;
    @(negedge clock);
    checa("rst_uart_dado", uart_dado_ler, 32'h0);
    checa("rst_uart_ack", {31'b0, uart_ack}, 32'h0);
    checa("rst2_mem_ler", {31'b0, mem_ler}, 32'h0);
    prox;
    reset_n = 1'b1;
    cpu_ler = 1'b0;
    t = ciclo;
    espera_ack(t + 1, 32'hA5A5A5A5, 1'b1);
    @(negedge clock);
    checa("pos_rst_mem_ler", {31'b0, mem_ler}, 32'h1);
    checa("pos_rst_mem_endereco", {25'b0, mem_endereco}, 32'h20);
    prox;
    uart_req = 1'b0;
    prox; prox; prox;

    checa("acks_pendentes", q_ack.size(), 32'h0);
    checa("paradas_pendentes", q_parada.size(), 32'h0);
    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
